// File: rtl/ten_gig_mac_tx_arbiter.sv
// rtl/ten_gig_mac_tx_arbiter.sv - packet-granular round-robin arbiter feeding the 10G MAC TX stream
// Optional feature macro: TX_ARB_PRIO0_EN (channel 0 wins every packet boundary it requests at).
module ten_gig_mac_tx_arbiter #(
  parameter int P_CH_NUM = 4,
  parameter int P_PTR_W  = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [P_CH_NUM*64-1:0] s_axis_tdata,
  input  logic [P_CH_NUM*80-1:0] s_axis_tuser,
  input  logic [P_CH_NUM*8-1:0]  s_axis_tkeep,
  input  logic [P_CH_NUM-1:0]    s_axis_tlast,
  input  logic [P_CH_NUM-1:0]    s_axis_tvalid,
  output logic [P_CH_NUM-1:0]    s_axis_tready,
  output logic [63:0]            m_axis_tdata,
  output logic [79:0]            m_axis_tuser,
  output logic [7:0]             m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [P_CH_NUM-1:0]    o_grant,
  output logic                   o_busy
);

  typedef enum logic {S_IDLE, S_XFER} state_t;

  state_t               r_state;
  logic [P_PTR_W-1:0]   r_ptr;
  logic [P_PTR_W-1:0]   r_idx;
  logic [P_CH_NUM-1:0]  r_grant;
  logic [P_PTR_W-1:0]   w_pick;
  logic                 w_req;
  logic                 w_done;

  function automatic logic [P_PTR_W-1:0] f_next(input logic [P_PTR_W-1:0] v);
    return (int'(v) == P_CH_NUM - 1) ? '0 : v + 1'b1;
  endfunction

  // Descending walk so the candidate closest to r_ptr is the last one written.
  always_comb begin
    int v_c;
    w_pick = r_ptr;
    v_c    = 0;
    for (int i = P_CH_NUM - 1; i >= 0; i--) begin
      v_c = int'(r_ptr) + i;
      if (v_c >= P_CH_NUM) v_c = v_c - P_CH_NUM;
      if (s_axis_tvalid[v_c]) w_pick = P_PTR_W'(v_c);
    end
`ifdef TX_ARB_PRIO0_EN
    if (s_axis_tvalid[0]) w_pick = '0;
`endif
  end

  assign w_req  = |s_axis_tvalid;
  assign w_done = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tuser  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tvalid = 1'b0;
    s_axis_tready = '0;
    if (r_state == S_XFER) begin
      for (int i = 0; i < P_CH_NUM; i++) begin
        if (r_idx == P_PTR_W'(i)) begin
          m_axis_tdata     = s_axis_tdata[i*64 +: 64];
          m_axis_tuser     = s_axis_tuser[i*80 +: 80];
          m_axis_tkeep     = s_axis_tkeep[i*8 +: 8];
          m_axis_tlast     = s_axis_tlast[i];
          m_axis_tvalid    = s_axis_tvalid[i];
          s_axis_tready[i] = m_axis_tready;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_grant <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_state <= S_XFER;
            r_idx   <= w_pick;
            r_grant <= {{(P_CH_NUM-1){1'b0}}, 1'b1} << w_pick;
`ifdef TX_ARB_PRIO0_EN
            if (w_pick != '0) r_ptr <= f_next(w_pick);
`else
            r_ptr <= f_next(w_pick);
`endif
          end
        end
        S_XFER: begin
          if (w_done) begin
            r_state <= S_IDLE;
            r_grant <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_grant = r_grant;
  assign o_busy  = (r_state == S_XFER);

endmodule

// File: tb/tb_ten_gig_mac_tx_arbiter.sv
// tb/tb_ten_gig_mac_tx_arbiter.sv - directed bench with an owner/pointer reference model for the TX arbiter
// Honours TX_ARB_PRIO0_EN the same way the design does.
module tb_ten_gig_mac_tx_arbiter;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*64-1:0] s_tdata;
  logic [N*80-1:0] s_tuser;
  logic [N*8-1:0]  s_tkeep;
  logic [N-1:0]    s_tlast;
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tready;
  logic [63:0]     m_tdata;
  logic [79:0]     m_tuser;
  logic [7:0]      m_tkeep;
  logic            m_tlast;
  logic            m_tvalid;
  logic            m_tready;
  logic [N-1:0]    grant;
  logic            busy;

  ten_gig_mac_tx_arbiter #(.P_CH_NUM(N), .P_PTR_W(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser), .s_axis_tkeep(s_tkeep),
    .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser), .m_axis_tkeep(m_tkeep),
    .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .o_grant(grant), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int rem[N];
  int plen[N];
  int beat[N];
  int pid[N];
  int own = -1;
  int ptr = 0;
  int n_tests = 0;
  int n_fail = 0;
  int gq[$];
  logic [63:0] dq[$];
  logic [N-1:0] prev_g = '0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int c = 0; c < N; c++) begin
      s_tvalid[c]          = rem[c] > 0;
      s_tlast[c]           = (rem[c] > 0) && (beat[c] == plen[c] - 1);
      s_tdata[c*64 +: 64]  = {8'hC0, 8'(c), 16'(pid[c]), 32'(beat[c])};
      s_tuser[c*80 +: 80]  = {16'(plen[c] * 8), 40'h02_0000_0000, 8'(c), 16'h0800};
      s_tkeep[c*8 +: 8]    = s_tlast[c] ? 8'h0F : 8'hFF;
    end
  endtask

  task automatic add_pkt(input int c, input int len, input int cnt);
    rem[c] = cnt; plen[c] = len; beat[c] = 0; pid[c] = 0;
    drive();
  endtask

  function automatic bit any_rem();
    for (int c = 0; c < N; c++) if (rem[c] > 0) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: compare against the model, sample handshakes, advance model and sources.
  task automatic tick();
    logic [N-1:0]   fire;
    logic [N-1:0]   eg;
    logic [N-1:0]   er;
    logic [153:0]   em;
    int             pick;
    @(negedge clk);
    eg = '0; er = '0; em = '0;
    if (own >= 0) begin
      eg[own] = 1'b1;
      er[own] = m_tready;
      em = {s_tdata[own*64 +: 64], s_tuser[own*80 +: 80], s_tkeep[own*8 +: 8], s_tlast[own], s_tvalid[own]};
    end
    chk("grant", grant, eg);
    chk("busy", busy, own >= 0);
    chk("s_tready", s_tready, er);
    chk("m_bus", {m_tdata, m_tuser, m_tkeep, m_tlast, m_tvalid}, em);
    fire = s_tvalid & s_tready;
    if (m_tvalid && m_tready) dq.push_back(m_tdata);
    if (grant != '0 && grant != prev_g)
      for (int c = 0; c < N; c++) if (grant[c]) gq.push_back(c);
    prev_g = grant;
    @(posedge clk);
    if (rst_n) begin
      if (own < 0) begin
        if (s_tvalid != '0) begin
          pick = -1;
`ifdef TX_ARB_PRIO0_EN
          if (s_tvalid[0]) pick = 0;
`endif
          for (int i = 0; i < N; i++)
            if (pick < 0 && s_tvalid[(ptr + i) % N]) pick = (ptr + i) % N;
          own = pick;
`ifdef TX_ARB_PRIO0_EN
          if (pick != 0) ptr = (pick + 1) % N;
`else
          ptr = (pick + 1) % N;
`endif
        end
      end else if (s_tvalid[own] && m_tready && s_tlast[own]) begin
        own = -1;
      end
    end
    #1;
    for (int c = 0; c < N; c++) begin
      if (fire[c]) begin
        if (beat[c] == plen[c] - 1) begin beat[c] = 0; pid[c]++; rem[c]--; end
        else beat[c]++;
      end
    end
    drive();
  endtask

  task automatic run_until_idle(input int budget, output int k);
    k = 0;
    while ((any_rem() || busy) && k < budget) begin tick(); k++; end
    chk("idle_within_budget", k < budget, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; own = -1; ptr = 0;
    for (int c = 0; c < N; c++) begin rem[c] = 0; plen[c] = 1; beat[c] = 0; pid[c] = 0; end
    drive();
    tick(); tick();
    rst_n = 1'b1;
    gq.delete(); dq.delete();
  endtask

  initial begin
    int k;
    int n2;
    m_tready = 1'b1;
    do_reset();
    chk("rst_grant", grant, 4'b0000);
    chk("rst_tvalid", m_tvalid, 1'b0);
    chk("rst_tready", s_tready, 4'b0000);

    // T1: single 4-beat ch1 packet
    add_pkt(1, 4, 1);
    tick();
    chk("t1_grant", grant, 4'b0010);
    run_until_idle(40, k);
    chk("t1_cycles", k, 4);
    chk("t1_nbeats", dq.size(), 4);
    for (int b = 0; b < 4; b++) chk("t1_data", dq[b], 64'hC001_0000_0000_0000 + 64'(b));
    chk("t1_busy", busy, 1'b0);

    // T2: all channels, 2-beat packets, ptr=0
    do_reset();
    for (int c = 0; c < N; c++) add_pkt(c, 2, 1);
    run_until_idle(60, k);
    chk("t2_cycles", k, 12);
    chk("t2_ngrants", gq.size(), 4);
    for (int c = 0; c < N; c++) chk("t2_order", gq[c], c);

    // T3: MAC tready toggling during a ch2 packet, ch3 waiting
    dq.delete();
    add_pkt(2, 4, 1);
    tick();
    add_pkt(3, 1, 1);
    k = 0;
    while ((any_rem() || busy) && k < 40) begin tick(); m_tready = ~m_tready; k++; end
    chk("t3_bounded", k < 40, 1'b1);
    m_tready = 1'b1;
    chk("t3_nbeats", dq.size(), 5);
    for (int b = 0; b < 4; b++) chk("t3_data", dq[b], 64'hC002_0000_0000_0000 + 64'(b));
    chk("t3_ch3", dq[4], 64'hC003_0000_0000_0000);

    // T4: reset at beat 3 of a 6-beat ch3 packet
    dq.delete();
    add_pkt(3, 6, 1);
    k = 0;
    while (dq.size() < 3 && k < 20) begin tick(); k++; end
    chk("t4_reach_beat3", dq.size(), 3);
    #2;
    rst_n = 1'b0; own = -1; ptr = 0;
    #1;
    chk("t4_tvalid", m_tvalid, 1'b0);
    chk("t4_grant", grant, 4'b0000);
    chk("t4_tready", s_tready, 4'b0000);
    for (int c = 0; c < N; c++) rem[c] = 0;
    drive();
    tick(); tick();
    rst_n = 1'b1;
    add_pkt(0, 1, 1);
    add_pkt(1, 1, 1);
    tick();
    chk("t4_grant0", grant, 4'b0001);
    run_until_idle(20, k);

    // T5: ch2 streams 1-beat packets, ch1 must get in
    do_reset();
    add_pkt(2, 1, 20);
    repeat (5) tick();
    add_pkt(1, 1, 1);
    gq.delete();
    k = 0;
    while (!(1 inside {gq}) && k < 20) begin tick(); k++; end
    chk("t5_ch1_granted", 1 inside {gq}, 1'b1);
    n2 = 0;
    foreach (gq[i]) if (gq[i] == 2) n2++;
    chk("t5_no_starve", n2 <= 1, 1'b1);
    run_until_idle(100, k);

    // T6: ch0 and ch3 competing with ptr=3, then ch0 arriving mid-ch3 packet
    do_reset();
    add_pkt(2, 1, 1);
    run_until_idle(20, k);
    gq.delete();
    add_pkt(0, 1, 1);
    add_pkt(3, 1, 1);
    run_until_idle(20, k);
    chk("t6_ngrants", gq.size(), 2);
`ifdef TX_ARB_PRIO0_EN
    chk("t6_first", gq[0], 0);
    chk("t6_second", gq[1], 3);
`else
    chk("t6_first", gq[0], 3);
    chk("t6_second", gq[1], 0);
`endif
    gq.delete();
    add_pkt(3, 4, 1);
    tick(); tick();
    add_pkt(0, 1, 1);
    run_until_idle(30, k);
    chk("t6_mid_ngrants", gq.size(), 2);
    chk("t6_mid_first", gq[0], 3);
    chk("t6_mid_second", gq[1], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
